// File: rtl/xor_csum_pkg.sv
// Shared types and helpers for the XOR checksum arbiter: FSM states, default sizes,
// and the round-robin search used by rr_arbiter.
package xor_csum_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 8;
    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {found, index}: the first set bit of req searching upward from
    // (last+1) mod nreq, wrapping around.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [2:0]          last,
        input int                  nreq
    );
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int off = 1; off <= MAX_NREQ; off++) begin
            if (off <= nreq) begin
                idx = (int'(last) + off) % nreq;
                if (!res[3] && req[idx]) begin
                    res = {1'b1, 3'(idx)};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xor_csum_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant plus encoded index of the
// first requester after last_grant. Zero latency, no state.
module rr_arbiter
    import xor_csum_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant_oh,
    output logic [IDW-1:0]  grant_idx
);

    logic [MAX_NREQ-1:0] req_ext;
    logic [2:0]          last_ext;
    logic [3:0]          pick;
    logic                unused_pick;

    always_comb begin
        req_ext               = '0;
        req_ext[NREQ-1:0]     = req;
        last_ext              = '0;
        last_ext[IDW-1:0]     = last_grant;
    end

    assign pick        = rr_pick(req_ext, last_ext, NREQ);
    assign grant_idx   = pick[IDW-1:0];
    assign unused_pick = ^pick;

    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i] = pick[3] && (grant_idx == IDW'(i));
        end
    end

endmodule

// File: rtl/xor_csum_arbiter.sv
// Shared XOR checksum accumulator with round-robin, frame-granular arbitration.
// Optional out_parity port when XOR_CSUM_PARITY_EN is defined.
module xor_csum_arbiter
    import xor_csum_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_last,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0] req_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
`ifdef XOR_CSUM_PARITY_EN
    output logic            out_parity,
`endif
    output logic [IDW-1:0]  out_id
);

    state_t          state, state_nxt;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  last_grant;
    logic [W-1:0]    acc;
    logic [W-1:0]    out_data_q;
    logic [IDW-1:0]  out_id_q;

    logic [NREQ-1:0] arb_oh;
    logic [IDW-1:0]  arb_idx;
    logic            any_req;
    logic [W-1:0]    word;
    logic            word_vld;
    logic            word_last;
    logic            beat;
    logic [W-1:0]    folded;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant_oh   (arb_oh),
        .grant_idx  (arb_idx)
    );

    assign any_req = |arb_oh;

    // Select the owning requester's lane; only its inputs matter while BUSY.
    always_comb begin
        word      = '0;
        word_vld  = 1'b0;
        word_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                word      = req_data[i*W +: W];
                word_vld  = req_valid[i];
                word_last = req_last[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state == BUSY) && (grant == IDW'(i));
        end
    end

    assign beat   = (state == BUSY) && word_vld;
    assign folded = acc ^ word;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)           state_nxt = BUSY;
            BUSY:    if (beat && word_last) state_nxt = DONE;
            DONE:    if (out_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant      <= '0;
            last_grant <= IDW'(NREQ - 1);
            acc        <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= arb_idx;
                        acc   <= '0;
                    end
                end
                BUSY: begin
                    if (beat) begin
                        acc <= folded;
                        if (word_last) begin
                            out_data_q <= folded;
                            out_id_q   <= grant;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        last_grant <= grant;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef XOR_CSUM_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (beat && word_last) begin
            parity_q <= ^folded;
        end
    end

    assign out_parity = parity_q;
`endif

    assign out_valid = (state == DONE);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_xor_csum_arbiter.sv
// Directed-vector bench for xor_csum_arbiter: reset, single frame, round robin,
// result backpressure, zero checksum, mid-frame stall and mid-frame reset.
module tb_xor_csum_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [IDW-1:0]    out_id;
`ifdef XOR_CSUM_PARITY_EN
    logic              out_parity;
`endif

    int nvec;
    int nerr;

    xor_csum_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef XOR_CSUM_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_id     (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one word on requester id and return at the negedge after it is taken.
    task automatic beat(input int id, input logic [W-1:0] d, input logic l);
        int n;
        req_valid[id]        = 1'b1;
        req_last[id]         = l;
        req_data[id*W +: W]  = d;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("beat_wait", 32'(n < 20), 32'd1);
        @(negedge clk);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    logic [W-1:0] rr_dat [NREQ];
    int           rr_exp [5];

    initial begin
        int n;
        nvec      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // Reset defaults
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data),  32'h0);
        chk("rst_id",    32'(out_id),    32'h0);

        // Single frame from requester 2: 3C ^ 0F ^ A5 = 96
        rst_n        = 1'b1;
        req_valid[2] = 1'b1;
        req_data[2*W +: W] = 8'h3C;
        chk("idle_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("arb_lat", 32'(req_ready), 32'b0100);
        beat(2, 8'h3C, 1'b0);
        beat(2, 8'h0F, 1'b0);
        chk("pre_valid", 32'(out_valid), 32'h0);
        beat(2, 8'hA5, 1'b1);
        chk("sf_valid", 32'(out_valid), 32'h1);
        chk("sf_data",  32'(out_data),  32'h96);
        chk("sf_id",    32'(out_id),    32'h2);
`ifdef XOR_CSUM_PARITY_EN
        chk("sf_par",   32'(out_parity), 32'h0);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        chk("sf_drain", 32'(out_valid), 32'h0);

        // Round robin after reset: 0,1,2,3 then wrap to 0
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rr_dat[0] = 8'h10; rr_dat[1] = 8'h21; rr_dat[2] = 8'h42; rr_dat[3] = 8'h84;
        rr_exp[0] = 0; rr_exp[1] = 1; rr_exp[2] = 2; rr_exp[3] = 3; rr_exp[4] = 0;
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = rr_dat[i];
        req_valid = '1;
        req_last  = '1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (req_ready == '0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("rr_grant", 32'(req_ready), 32'(1) << rr_exp[k]);
            @(negedge clk);
            chk("rr_valid", 32'(out_valid), 32'h1);
            chk("rr_id",    32'(out_id),    32'(rr_exp[k]));
            chk("rr_data",  32'(out_data),  32'(rr_dat[rr_exp[k]]));
        end
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);

        // Backpressure: requester 1 frame C3 ^ 5A = 99, requester 3 left pending
        out_ready = 1'b0;
        beat(1, 8'hC3, 1'b0);
        req_valid[3] = 1'b1;
        req_last[3]  = 1'b1;
        req_data[3*W +: W] = 8'h77;
        beat(1, 8'h5A, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_data",  32'(out_data),  32'h99);
            chk("bp_id",    32'(out_id),    32'h1);
            chk("bp_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain", 32'(out_valid), 32'h0);
        @(negedge clk);
        chk("bp_next",  32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid[3] = 1'b0;
        req_last[3]  = 1'b0;
        chk("p3_data", 32'(out_data), 32'h77);
        chk("p3_id",   32'(out_id),   32'h3);
        @(negedge clk);

        // Frame XORing to zero still produces a result
        beat(0, 8'h5A, 1'b0);
        beat(0, 8'h5A, 1'b1);
        chk("z_valid", 32'(out_valid), 32'h1);
        chk("z_data",  32'(out_data),  32'h0);
`ifdef XOR_CSUM_PARITY_EN
        chk("z_par",   32'(out_parity), 32'h0);
`endif
        @(negedge clk);

        // Stall mid-frame: 11, three idle cycles, 22 (last) -> 33
        beat(1, 8'h11, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("st_ready", 32'(req_ready), 32'b0010);
            chk("st_valid", 32'(out_valid), 32'h0);
            @(negedge clk);
        end
        beat(1, 8'h22, 1'b1);
        chk("st_out",  32'(out_valid), 32'h1);
        chk("st_data", 32'(out_data),  32'h33);
        chk("st_id",   32'(out_id),    32'h1);
        @(negedge clk);

        // Reset after two of four words discards the frame
        beat(2, 8'h01, 1'b0);
        beat(2, 8'h02, 1'b0);
        rst_n        = 1'b0;
        req_valid[2] = 1'b1;
        req_data[2*W +: W] = 8'h03;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("mr_valid", 32'(out_valid), 32'h0);
            chk("mr_ready", 32'(req_ready), 32'h0);
        end
        rst_n        = 1'b1;
        req_valid[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mr_quiet", 32'(out_valid), 32'h0);
        end
        beat(0, 8'h55, 1'b1);
        chk("mr_out",  32'(out_valid), 32'h1);
        chk("mr_data", 32'(out_data),  32'h55);
        chk("mr_id",   32'(out_id),    32'h0);
`ifdef XOR_CSUM_PARITY_EN
        chk("mr_par",  32'(out_parity), 32'h0);
`endif
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
